// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads the PC, fetches from instruction memory, holds the word for decode.
// Optional memory timeout watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter int ADDR_W      = 8,
  parameter int INSTR_W     = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               fetch_en,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               flush,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ack,
  output logic               incr_pc,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic               fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_live;
  logic              drop;
  logic              timeout;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_timeout_range
    $error("fetch_unit: TIMEOUT_CYC must be within 1..255");
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (fetch_en && !flush) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_next = (drop || flush) ? IDLE : HOLD;
        end else if (timeout) begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        if (flush) begin
          state_next = IDLE;
        end else if (ir_ready) begin
          state_next = fetch_en ? REQ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A fetch issued straight out of HOLD drives the address from pc in its first
  // cycle, because the PC only finishes incrementing on the edge that enters REQ.
  always_comb begin
    mem_rd   = (state == REQ);
    ir_valid = (state == HOLD);
    mem_addr = (state == REQ && addr_live) ? pc : addr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= '0;
      addr_live <= 1'b0;
      drop      <= 1'b0;
      incr_pc   <= 1'b0;
      ir        <= '0;
      ir_pc     <= '0;
    end else begin
      incr_pc <= 1'b0;
      case (state)
        IDLE: begin
          if (state_next == REQ) begin
            addr_q <= pc;
          end
        end
        REQ: begin
          addr_q    <= mem_addr;
          addr_live <= 1'b0;
          if (mem_ack) begin
            drop <= 1'b0;
            if (!drop && !flush) begin
              ir      <= mem_rdata;
              ir_pc   <= mem_addr;
              incr_pc <= 1'b1;
            end
          end else if (timeout) begin
            drop <= 1'b0;
          end else if (flush) begin
            // The read cannot be cancelled; remember to throw its data away.
            drop <= 1'b1;
          end
        end
        HOLD: begin
          if (state_next == REQ) begin
            addr_live <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timeout = (state == REQ) && !mem_ack && (wait_cnt == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state == REQ && state_next == REQ) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= '0;
      end
      if (timeout) begin
        fetch_err <= 1'b1;
      end
    end
  end
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC model, scripted/zero-wait memory, scoreboard of expected instructions.
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] ir;
    logic [7:0]  pc;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        fetch_en;
  logic [7:0]  pc_q;
  logic        flush;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        incr_pc;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        fetch_err;

  logic        pc_load;
  logic [7:0]  pc_load_val;
  logic        auto_ack;
  logic        man_ack;
  logic [15:0] man_rdata;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic prev_valid;
  logic prev_incr;

  function automatic logic [15:0] data_of(input logic [7:0] a);
    return {a, ~a};
  endfunction

  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en), .pc(pc_q), .flush(flush),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .incr_pc(incr_pc), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_ack   = auto_ack ? mem_rd : man_ack;
  assign mem_rdata = auto_ack ? data_of(mem_addr) : man_rdata;

  // Program counter model: controller load wins over increment.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_q <= 8'h00;
    else if (pc_load) pc_q <= pc_load_val;
    else if (incr_pc) pc_q <= pc_q + 8'h01;
  end

  // Scoreboard consumer: every new instruction in ir must match the next expected entry.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
      prev_incr  = 1'b0;
    end else begin
      if (ir_valid && !prev_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("[TB] FAIL sb_unexpected: got ir=%h ir_pc=%h, expected no instruction", ir, ir_pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({ir, ir_pc} !== {e.ir, e.pc}) begin
            n_err++;
            $display("[TB] FAIL sb_instr: got ir=%h ir_pc=%h, expected ir=%h ir_pc=%h", ir, ir_pc, e.ir, e.pc);
          end
        end
      end
      if (incr_pc) begin
        n_cmp++;
        if (prev_incr || !(ir_valid && !prev_valid)) begin
          n_err++;
          $display("[TB] FAIL incr_pulse: got incr_pc=1 prev=%b new_valid=%b, expected single pulse with new instruction",
                   prev_incr, ir_valid && !prev_valid);
        end
      end
      prev_valid = ir_valid;
      prev_incr  = incr_pc;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic reset_dut();
    reset_n     = 1'b0;
    fetch_en    = 1'b0;
    flush       = 1'b0;
    ir_ready    = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = 8'h00;
    auto_ack    = 1'b0;
    man_ack     = 1'b0;
    man_rdata   = 16'h0000;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic load_pc(input logic [7:0] v);
    @(negedge clk);
    pc_load     = 1'b1;
    pc_load_val = v;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp += 7;
    if (mem_rd !== 1'b0) begin n_err++; $display("[TB] FAIL rst_mem_rd: got %b expected 0", mem_rd); end
    if (mem_addr !== 8'h00) begin n_err++; $display("[TB] FAIL rst_mem_addr: got %h expected 00", mem_addr); end
    if (incr_pc !== 1'b0) begin n_err++; $display("[TB] FAIL rst_incr_pc: got %b expected 0", incr_pc); end
    if (ir !== 16'h0000) begin n_err++; $display("[TB] FAIL rst_ir: got %h expected 0000", ir); end
    if (ir_pc !== 8'h00) begin n_err++; $display("[TB] FAIL rst_ir_pc: got %h expected 00", ir_pc); end
    if (ir_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_ir_valid: got %b expected 0", ir_valid); end
    if (fetch_err !== 1'b0) begin n_err++; $display("[TB] FAIL rst_fetch_err: got %b expected 0", fetch_err); end
    reset_n = 1'b1;
  endtask

  task automatic test_single_fetch();
    bit ok = 0;
    int pulses = 0;
    load_pc(8'h00);
    fetch_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_rd) begin ok = 1; break; end
    end
    fetch_en = 1'b0;
    n_cmp += 2;
    if (!ok) begin n_err++; $display("[TB] FAIL single_rd: got no mem_rd, expected request within 10 cycles"); end
    if (mem_addr !== 8'h00) begin n_err++; $display("[TB] FAIL single_addr: got %h expected 00", mem_addr); end
    repeat (2) @(negedge clk);
    man_ack   = 1'b1;
    man_rdata = 16'h1234;
    exp_q.push_back({16'h1234, 8'h00});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      man_ack = 1'b0;
      if (incr_pc) pulses++;
    end
    n_cmp += 5;
    if (pulses != 1) begin n_err++; $display("[TB] FAIL single_incr: got %0d pulses expected 1", pulses); end
    if (ir_valid !== 1'b1) begin n_err++; $display("[TB] FAIL single_valid: got %b expected 1", ir_valid); end
    if (ir !== 16'h1234) begin n_err++; $display("[TB] FAIL single_ir: got %h expected 1234", ir); end
    if (ir_pc !== 8'h00) begin n_err++; $display("[TB] FAIL single_ir_pc: got %h expected 00", ir_pc); end
    if (pc_q !== 8'h01) begin n_err++; $display("[TB] FAIL single_pc: got %h expected 01", pc_q); end
    ir_ready = 1'b1;
    @(negedge clk);
    ir_ready = 1'b0;
    n_cmp++;
    if (ir_valid !== 1'b0) begin n_err++; $display("[TB] FAIL single_release: got %b expected 0", ir_valid); end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int t = 0;
    int rise[3];
    logic pv = 1'b0;
    load_pc(8'h10);
    for (int k = 0; k < 3; k++) exp_q.push_back({data_of(8'h10 + 8'(k)), 8'h10 + 8'(k)});
    auto_ack = 1'b1;
    ir_ready = 1'b1;
    fetch_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      t++;
      if (ir_valid && !pv) begin
        rise[got] = t;
        got++;
        if (got == 3) begin fetch_en = 1'b0; break; end
      end
      pv = ir_valid;
    end
    n_cmp++;
    if (got != 3) begin
      n_err++;
      $display("[TB] FAIL b2b_count: got %0d instructions expected 3", got);
    end else begin
      n_cmp += 2;
      if (rise[1] - rise[0] != 2) begin n_err++; $display("[TB] FAIL b2b_gap1: got %0d cycles expected 2", rise[1] - rise[0]); end
      if (rise[2] - rise[1] != 2) begin n_err++; $display("[TB] FAIL b2b_gap2: got %0d cycles expected 2", rise[2] - rise[1]); end
    end
    @(negedge clk);
    n_cmp += 2;
    if (mem_rd !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_stop: got mem_rd=%b expected 0", mem_rd); end
    if (pc_q !== 8'h13) begin n_err++; $display("[TB] FAIL b2b_pc: got %h expected 13", pc_q); end
    auto_ack = 1'b0;
    ir_ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    bit ok = 0;
    load_pc(8'h20);
    exp_q.push_back({data_of(8'h20), 8'h20});
    auto_ack = 1'b1;
    ir_ready = 1'b0;
    fetch_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ir_valid) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin n_err++; $display("[TB] FAIL stall_valid: got no ir_valid expected within 10 cycles"); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp += 4;
      if (ir !== data_of(8'h20)) begin n_err++; $display("[TB] FAIL stall_ir: got %h expected %h", ir, data_of(8'h20)); end
      if (ir_pc !== 8'h20) begin n_err++; $display("[TB] FAIL stall_ir_pc: got %h expected 20", ir_pc); end
      if (mem_rd !== 1'b0) begin n_err++; $display("[TB] FAIL stall_mem_rd: got %b expected 0", mem_rd); end
      if (incr_pc !== 1'b0) begin n_err++; $display("[TB] FAIL stall_incr: got %b expected 0", incr_pc); end
    end
    fetch_en = 1'b0;
    ir_ready = 1'b1;
    @(negedge clk);
    ir_ready = 1'b0;
    auto_ack = 1'b0;
  endtask

  task automatic test_flush_inflight();
    bit ok = 0;
    bit bad = 0;
    load_pc(8'h30);
    fetch_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_rd) begin ok = 1; break; end
    end
    fetch_en = 1'b0;
    n_cmp++;
    if (!ok) begin n_err++; $display("[TB] FAIL flush_rd: got no mem_rd expected request"); end
    @(negedge clk);
    flush       = 1'b1;
    pc_load     = 1'b1;
    pc_load_val = 8'h40;
    @(negedge clk);
    flush   = 1'b0;
    pc_load = 1'b0;
    n_cmp += 2;
    if (mem_rd !== 1'b1) begin n_err++; $display("[TB] FAIL flush_wait_rd: got %b expected 1", mem_rd); end
    if (mem_addr !== 8'h30) begin n_err++; $display("[TB] FAIL flush_addr_stable: got %h expected 30", mem_addr); end
    @(negedge clk);
    @(negedge clk);
    man_ack   = 1'b1;
    man_rdata = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      man_ack = 1'b0;
      if (ir_valid || incr_pc || mem_rd) bad = 1;
    end
    n_cmp++;
    if (bad) begin n_err++; $display("[TB] FAIL flush_discard: got valid/incr/rd activity=1 expected 0"); end
    ok = 0;
    fetch_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_rd) begin ok = 1; break; end
    end
    fetch_en = 1'b0;
    n_cmp += 2;
    if (!ok) begin n_err++; $display("[TB] FAIL flush_refetch: got no mem_rd expected request"); end
    if (mem_addr !== 8'h40) begin n_err++; $display("[TB] FAIL flush_new_pc: got %h expected 40", mem_addr); end
    man_ack   = 1'b1;
    man_rdata = 16'hCAFE;
    exp_q.push_back({16'hCAFE, 8'h40});
    @(negedge clk);
    man_ack = 1'b0;
    n_cmp++;
    if (ir_valid !== 1'b1) begin n_err++; $display("[TB] FAIL flush_after_valid: got %b expected 1", ir_valid); end
    ir_ready = 1'b1;
    @(negedge clk);
    ir_ready = 1'b0;
  endtask

  task automatic test_flush_ready();
    bit ok = 0;
    load_pc(8'h50);
    exp_q.push_back({data_of(8'h50), 8'h50});
    auto_ack = 1'b1;
    ir_ready = 1'b0;
    fetch_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ir_valid) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin n_err++; $display("[TB] FAIL fr_valid: got no ir_valid expected within 10 cycles"); end
    flush    = 1'b1;
    ir_ready = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    ir_ready = 1'b0;
    fetch_en = 1'b0;
    n_cmp += 3;
    if (ir_valid !== 1'b0) begin n_err++; $display("[TB] FAIL fr_valid_drop: got %b expected 0", ir_valid); end
    if (mem_rd !== 1'b0) begin n_err++; $display("[TB] FAIL fr_no_rd: got %b expected 0", mem_rd); end
    if (incr_pc !== 1'b0) begin n_err++; $display("[TB] FAIL fr_incr: got %b expected 0", incr_pc); end
    @(negedge clk);
    n_cmp++;
    if (mem_rd !== 1'b0) begin n_err++; $display("[TB] FAIL fr_idle: got mem_rd=%b expected 0", mem_rd); end
    auto_ack = 1'b0;
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    bit ok = 0;
    load_pc(8'h60);
    fetch_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_rd) begin ok = 1; break; end
    end
    fetch_en = 1'b0;
    n_cmp += 2;
    if (!ok) begin n_err++; $display("[TB] FAIL to_rd: got no mem_rd expected request"); end
    if (fetch_err !== 1'b0) begin n_err++; $display("[TB] FAIL to_early1: got %b expected 0", fetch_err); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp += 2;
      if (mem_rd !== 1'b1) begin n_err++; $display("[TB] FAIL to_wait_rd: got %b expected 1", mem_rd); end
      if (fetch_err !== 1'b0) begin n_err++; $display("[TB] FAIL to_early: got %b expected 0", fetch_err); end
    end
    @(negedge clk);
    n_cmp += 3;
    if (fetch_err !== 1'b1) begin n_err++; $display("[TB] FAIL to_err: got %b expected 1", fetch_err); end
    if (mem_rd !== 1'b0) begin n_err++; $display("[TB] FAIL to_rd_drop: got %b expected 0", mem_rd); end
    if (pc_q !== 8'h60) begin n_err++; $display("[TB] FAIL to_pc: got %h expected 60", pc_q); end
    exp_q.push_back({data_of(8'h60), 8'h60});
    auto_ack = 1'b1;
    fetch_en = 1'b1;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ir_valid) begin ok = 1; break; end
    end
    fetch_en = 1'b0;
    n_cmp += 2;
    if (!ok) begin n_err++; $display("[TB] FAIL to_refetch: got no ir_valid expected instruction"); end
    if (fetch_err !== 1'b1) begin n_err++; $display("[TB] FAIL to_sticky: got %b expected 1", fetch_err); end
    ir_ready = 1'b1;
    @(negedge clk);
    ir_ready = 1'b0;
    auto_ack = 1'b0;
    reset_dut();
    n_cmp++;
    if (fetch_err !== 1'b0) begin n_err++; $display("[TB] FAIL to_reset_clear: got %b expected 0", fetch_err); end
  endtask
`else
  task automatic test_wait_forever();
    bit ok = 0;
    load_pc(8'h60);
    fetch_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_rd) begin ok = 1; break; end
    end
    fetch_en = 1'b0;
    n_cmp++;
    if (!ok) begin n_err++; $display("[TB] FAIL wf_rd: got no mem_rd expected request"); end
    repeat (20) @(negedge clk);
    n_cmp += 3;
    if (mem_rd !== 1'b1) begin n_err++; $display("[TB] FAIL wf_still_rd: got %b expected 1", mem_rd); end
    if (mem_addr !== 8'h60) begin n_err++; $display("[TB] FAIL wf_addr: got %h expected 60", mem_addr); end
    if (fetch_err !== 1'b0) begin n_err++; $display("[TB] FAIL wf_err: got %b expected 0", fetch_err); end
    reset_n = 1'b0;
    #1;
    n_cmp += 2;
    if (mem_rd !== 1'b0) begin n_err++; $display("[TB] FAIL wf_async_rst: got mem_rd=%b expected 0", mem_rd); end
    if (mem_addr !== 8'h00) begin n_err++; $display("[TB] FAIL wf_rst_addr: got %h expected 00", mem_addr); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask
`endif

  initial begin
    reset_dut();
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_hold_stall();
    test_flush_inflight();
    test_flush_ready();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`else
    test_wait_forever();
`endif
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL sb_leftover: got %0d pending entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
